// File: rtl/vga_timing_pkg.sv
// Shared constants and helpers for the VGA raster timing generator.
// Defaults describe 640x480@60 with a 25 MHz pixel clock.
package vga_timing_pkg;

    localparam int DEF_H_ACTIVE   = 640;
    localparam int DEF_H_FP       = 16;
    localparam int DEF_H_SYNC     = 96;
    localparam int DEF_H_BP       = 48;
    localparam int DEF_V_ACTIVE   = 480;
    localparam int DEF_V_FP       = 10;
    localparam int DEF_V_SYNC     = 2;
    localparam int DEF_V_BP       = 33;
    localparam int DEF_CW         = 16;
    localparam int MAX_SYNC_DELAY = 7;

    function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // The counters must hold TOTAL-1 on both axes, and the delay line is capped.
    function automatic bit timing_params_ok(input int cw, input int h_total, input int v_total,
                                            input int sync_delay);
        longint span;
        span = longint'(1) << cw;
        return (longint'(h_total) <= span) && (longint'(v_total) <= span) &&
               (sync_delay >= 0) && (sync_delay <= MAX_SYNC_DELAY);
    endfunction

endpackage

// File: rtl/vga_timing_generator_axis_counter.sv
// One raster axis: wrapping counter plus region flags registered from the next
// count, so the flags always describe the count shown on the same cycle.
module axis_counter
    import vga_timing_pkg::*;
#(
    parameter int   CW         = DEF_CW,
    parameter int   TOTAL      = 800,
    parameter int   ACTIVE     = 640,
    parameter int   SYNC_START = 656,
    parameter int   SYNC_LEN   = 96,
    parameter logic POL        = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    output logic [CW-1:0] count,
    output logic          wrap,
    output logic          first,
    output logic          active,
    output logic          sync
);

    localparam logic [CW-1:0] LAST       = CW'(TOTAL - 1);
    localparam logic [CW-1:0] ACTIVE_END = CW'(ACTIVE - 1);
    localparam logic [CW-1:0] SYNC_FIRST = CW'(SYNC_START);
    localparam logic [CW-1:0] SYNC_LAST  = CW'(SYNC_START + SYNC_LEN - 1);

    logic [CW-1:0] count_next;

    always_comb begin
        count_next = (count == LAST) ? '0 : count + CW'(1);
    end

    // wrap/first stay low in reset even though count sits at LAST.
    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= LAST;
            wrap   <= 1'b0;
            first  <= 1'b0;
            active <= 1'b0;
            sync   <= ~POL;
        end else if (inc) begin
            count  <= count_next;
            wrap   <= (count_next == LAST);
            first  <= (count_next == '0);
            active <= (count_next <= ACTIVE_END);
            sync   <= ((count_next >= SYNC_FIRST) && (count_next <= SYNC_LAST)) ? POL : ~POL;
        end
    end

endmodule

// File: rtl/vga_timing_generator.sv
// Parametrised VGA raster timing: H/V counters, level strobes, and sync/blank
// outputs with an optional pixel-enabled delay line.
module vga_timing_generator
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE   = DEF_H_ACTIVE,
    parameter int   H_FP       = DEF_H_FP,
    parameter int   H_SYNC     = DEF_H_SYNC,
    parameter int   H_BP       = DEF_H_BP,
    parameter int   V_ACTIVE   = DEF_V_ACTIVE,
    parameter int   V_FP       = DEF_V_FP,
    parameter int   V_SYNC     = DEF_V_SYNC,
    parameter int   V_BP       = DEF_V_BP,
    parameter logic H_SYNC_POL = 1'b0,
    parameter logic V_SYNC_POL = 1'b0,
    parameter int   SYNC_DELAY = 0,
    parameter int   CW         = DEF_CW
) (
    input  logic          clk_25Mhz,
    input  logic          rst,
    input  logic          pix_en,
    output logic [CW-1:0] h_count,
    output logic [CW-1:0] v_count,
    output logic          hsync,
    output logic          vsync,
    output logic          video_on,
    output logic          line_start,
    output logic          line_end,
    output logic          frame_start,
    output logic          frame_end
);

    localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);

    if (!timing_params_ok(CW, H_TOTAL, V_TOTAL, SYNC_DELAY)) begin : g_bad_params
        $error("vga_timing_generator: CW too narrow for the totals or SYNC_DELAY outside 0..7");
    end

    logic h_wrap, h_first, h_active, h_sync;
    logic v_wrap, v_first, v_active, v_sync;
    logic v_inc;

    // V advances on the very edge that wraps H, so no lag between the axes.
    assign v_inc = pix_en && (h_count == H_LAST);

    axis_counter #(
        .CW(CW), .TOTAL(H_TOTAL), .ACTIVE(H_ACTIVE),
        .SYNC_START(H_ACTIVE + H_FP), .SYNC_LEN(H_SYNC), .POL(H_SYNC_POL)
    ) u_h (
        .clk(clk_25Mhz), .rst(rst), .inc(pix_en), .count(h_count),
        .wrap(h_wrap), .first(h_first), .active(h_active), .sync(h_sync)
    );

    axis_counter #(
        .CW(CW), .TOTAL(V_TOTAL), .ACTIVE(V_ACTIVE),
        .SYNC_START(V_ACTIVE + V_FP), .SYNC_LEN(V_SYNC), .POL(V_SYNC_POL)
    ) u_v (
        .clk(clk_25Mhz), .rst(rst), .inc(v_inc), .count(v_count),
        .wrap(v_wrap), .first(v_first), .active(v_active), .sync(v_sync)
    );

    assign line_start  = h_first;
    assign line_end    = h_wrap;
    assign frame_start = h_first & v_first;
    assign frame_end   = h_wrap & v_wrap;

    logic [2:0] raw;
    assign raw = {h_sync, v_sync, h_active & v_active};

    if (SYNC_DELAY == 0) begin : g_no_delay
        assign {hsync, vsync, video_on} = raw;
    end else begin : g_delay
        localparam logic [2:0] IDLE = {~H_SYNC_POL, ~V_SYNC_POL, 1'b0};
        logic [2:0] stage [SYNC_DELAY];

        always_ff @(posedge clk_25Mhz) begin
            if (rst) begin
                for (int i = 0; i < SYNC_DELAY; i++) stage[i] <= IDLE;
            end else if (pix_en) begin
                stage[0] <= raw;
                for (int i = 1; i < SYNC_DELAY; i++) stage[i] <= stage[i-1];
            end
        end

        assign {hsync, vsync, video_on} = stage[SYNC_DELAY-1];
    end

endmodule
